// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier.
// State encoding of the control FSM is fixed here so datapath and control agree.
package mult_pkg;

    localparam logic [1:0] S0 = 2'd0;  // idle
    localparam logic [1:0] S1 = 2'd1;  // test multiplier bit / add
    localparam logic [1:0] S2 = 2'd2;  // shift after add
    localparam logic [1:0] S3 = 2'd3;  // done

endpackage

// File: rtl/shift_add_control.sv
// Control FSM of the shift-and-add multiplier: sequences Load, Ad and Sh
// from the multiplier LSB (M) and the bit-counter terminal flag (K).
module shift_add_control
    import mult_pkg::*;
(
    input  logic Clk,
    input  logic Rst,
    input  logic St,
    input  logic K,
    input  logic M,
    output logic Idle,
    output logic Done,
    output logic Load,
    output logic Sh,
    output logic Ad
);

    logic [1:0] state_r;
    logic [1:0] next_state_s;

    // State register; reset returns to idle immediately, aborting any operation.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r <= S0;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and Mealy strobe decode; every strobe defaults low.
    always_comb begin
        next_state_s = S0;
        Idle         = 1'b0;
        Done         = 1'b0;
        Load         = 1'b0;
        Sh           = 1'b0;
        Ad           = 1'b0;
        case (state_r)
            S0: begin
                Idle = 1'b1;
                if (St) begin
                    Load         = 1'b1;
                    next_state_s = S1;
                end else begin
                    next_state_s = S0;
                end
            end
            S1: begin
                // An add always costs an extra shift cycle, so K waits for S2.
                if (M) begin
                    Ad           = 1'b1;
                    next_state_s = S2;
                end else if (K) begin
                    Sh           = 1'b1;
                    next_state_s = S3;
                end else begin
                    Sh           = 1'b1;
                    next_state_s = S1;
                end
            end
            S2: begin
                Sh = 1'b1;
                if (K) begin
                    next_state_s = S3;
                end else begin
                    next_state_s = S1;
                end
            end
            S3: begin
                Done         = 1'b1;
                next_state_s = S0;
            end
            default: begin
                next_state_s = S0;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_add_control.sv
// Self-checking bench for shift_add_control: directed reset/abort cases plus
// randomized multiplications checked against a per-bit cost model.
module tb_shift_add_control;

    logic Clk = 1'b0;
    logic Rst, St, K, M;
    logic Idle, Done, Load, Sh, Ad;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Expected vectors are ordered {Idle, Done, Load, Sh, Ad}.
    localparam logic [4:0] E_IDLE = 5'b10000;
    localparam logic [4:0] E_LOAD = 5'b10100;
    localparam logic [4:0] E_ADD  = 5'b00001;
    localparam logic [4:0] E_SHFT = 5'b00010;
    localparam logic [4:0] E_DONE = 5'b01000;

    shift_add_control dut (
        .Clk  (Clk),
        .Rst  (Rst),
        .St   (St),
        .K    (K),
        .M    (M),
        .Idle (Idle),
        .Done (Done),
        .Load (Load),
        .Sh   (Sh),
        .Ad   (Ad)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {Idle, Done, Load, Sh, Ad};
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    // One clock cycle: apply inputs, check strobes mid-cycle, advance.
    task automatic cyc_chk(input string tag, input logic st, input logic m,
                           input logic k, input logic [4:0] exp);
        St = st;
        M  = m;
        K  = k;
        #1;
        check(tag, exp);
        next_cycle();
    endtask

    // Whole multiplication of an n-bit multiplier, LSB first. Each 1 bit costs
    // an add cycle and a shift cycle, each 0 bit one shift cycle, then Done.
    task automatic run_op(input int n, input logic [15:0] mult, input logic hold);
        int load_cyc, done_cyc, ones;
        logic last;
        load_cyc = -1;
        done_cyc = -1;
        ones     = 0;
        for (int i = 0; i < n; i++) ones += int'(mult[i]);

        St = 1'b1; M = 1'($urandom); K = 1'($urandom);
        #1;
        check("load", E_LOAD);
        if (Load === 1'b1) load_cyc = cyc;
        next_cycle();

        for (int i = 0; i < n; i++) begin
            last = (i == n - 1);
            if (mult[i]) begin
                cyc_chk("add", hold | 1'($urandom), 1'b1, 1'($urandom), E_ADD);
                cyc_chk("shift_after_add", hold | 1'($urandom), 1'($urandom), last, E_SHFT);
            end else begin
                cyc_chk("shift", hold | 1'($urandom), 1'b0, last, E_SHFT);
            end
        end

        St = hold | 1'($urandom); M = 1'($urandom); K = 1'($urandom);
        #1;
        check("done", E_DONE);
        if (Done === 1'b1) done_cyc = cyc;
        next_cycle();

        n_cmp++;
        assert ((load_cyc >= 0) && (done_cyc >= 0) && (done_cyc - load_cyc == n + ones + 1)) else begin
            n_err++;
            $error("FAIL latency n=%0d mult=%h observed=%0d expected=%0d",
                   n, mult, done_cyc - load_cyc, n + ones + 1);
        end
    endtask

    initial begin
        Rst = 1'b1; St = 1'b0; K = 1'b0; M = 1'b0;
        #2;
        check("reset_idle", E_IDLE);
        St = 1'b1;
        #1;
        check("reset_load_follows_st", E_LOAD);
        St = 1'b0;
        next_cycle();
        Rst = 1'b0;

        // Idle hold.
        cyc_chk("idle_hold0", 1'b0, 1'b1, 1'b1, E_IDLE);
        cyc_chk("idle_hold1", 1'b0, 1'b0, 1'b1, E_IDLE);

        // Full run: Load, Ad, Sh, Sh, Done.
        run_op(2, 16'h0001, 1'b0);
        cyc_chk("idle_after_done", 1'b0, 1'b0, 1'b0, E_IDLE);

        // Single-bit operands: last-bit from S1 and from S2.
        run_op(1, 16'h0000, 1'b0);
        run_op(1, 16'h0001, 1'b0);
        cyc_chk("idle_after_single", 1'b0, 1'b0, 1'b0, E_IDLE);

        // St held high through a run reloads straight from S0.
        run_op(4, 16'h000B, 1'b1);
        run_op(3, 16'h0005, 1'b1);
        cyc_chk("idle_after_hold", 1'b0, 1'b0, 1'b0, E_IDLE);

        // Async reset mid-operation in S2: immediate idle, no Done later.
        St = 1'b1; M = 1'b0; K = 1'b0;
        #1;
        check("abort_load", E_LOAD);
        next_cycle();
        cyc_chk("abort_add", 1'b0, 1'b1, 1'b0, E_ADD);
        St = 1'b0; M = 1'b0; K = 1'b1;
        #1;
        check("abort_in_s2", E_SHFT);
        Rst = 1'b1;
        #1;
        check("abort_rst_async", E_IDLE);
        St = 1'b1;
        #1;
        check("abort_rst_load", E_LOAD);
        St = 1'b0;
        #1;
        Rst = 1'b0;
        next_cycle();
        for (int i = 0; i < 3; i++) cyc_chk("abort_no_done", 1'b0, 1'($urandom), 1'($urandom), E_IDLE);

        // Randomized operations with random gaps.
        for (int t = 0; t < 30; t++) begin
            int n;
            int gap;
            n   = int'($urandom_range(1, 16));
            gap = int'($urandom_range(0, 2));
            run_op(n, 16'($urandom), 1'($urandom_range(0, 3) == 0));
            for (int g = 0; g < gap; g++) cyc_chk("rand_gap", 1'b0, 1'($urandom), 1'($urandom), E_IDLE);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
